// File: rtl/multi_edge_detector_if.sv
// Channel bus for multi_edge_detector: raw levels, mode and clears in;
// event pulses, sticky flags and the event counter out.
interface multi_edge_detector_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]   x;
    logic [2*WIDTH-1:0] mode;
    logic [WIDTH-1:0]   clr;
    logic               count_clr;
    logic [WIDTH-1:0]   y;
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   fall;
    logic [WIDTH-1:0]   pending;
    logic [CNT_W-1:0]   event_count;

    modport master (
        output x, mode, clr, count_clr,
        input  y, rise, fall, pending, event_count
    );

    modport slave (
        input  x, mode, clr, count_clr,
        output y, rise, fall, pending, event_count
    );
endinterface

// File: rtl/multi_edge_detector.sv
// WIDTH-channel edge detector: per-channel synchroniser, glitch filter and
// mode mask, with one-cycle pulses, sticky pending flags and a saturating count.
module med_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int F           = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_x,
    input  logic [1:0] i_mode,
    input  logic       i_clr,
    output logic       o_y_next,
    output logic       o_y,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_pending
);
    localparam int CW = $clog2(F + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(F - 1);

    typedef enum logic [1:0] {ST_LOW, ST_Q_HI, ST_HIGH, ST_Q_LO} state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic            w_s, w_rise_nx, w_fall_nx;
    logic            r_y, r_rise, r_fall, r_pending;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = i_x;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= i_x;
                    for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Qualifying states count how long the new level has held; any bounce
    // back to the old level drops straight to the settled state.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_s) begin
                    if (F == 1) begin
                        w_state_nx = ST_HIGH;
                        w_rise_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_Q_HI;
                        w_cnt_nx   = CW'(1);
                    end
                end
            end
            ST_Q_HI: begin
                if (!w_s) begin
                    w_state_nx = ST_LOW;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = ST_HIGH;
                    w_rise_nx  = 1'b1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            ST_HIGH: begin
                if (!w_s) begin
                    if (F == 1) begin
                        w_state_nx = ST_LOW;
                        w_fall_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_Q_LO;
                        w_cnt_nx   = CW'(1);
                    end
                end
            end
            ST_Q_LO: begin
                if (w_s) begin
                    w_state_nx = ST_HIGH;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = ST_LOW;
                    w_fall_nx  = 1'b1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = ST_LOW;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign o_y_next = (w_rise_nx & i_mode[0]) | (w_fall_nx & i_mode[1]);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_LOW;
            r_cnt     <= '0;
            r_y       <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_y       <= o_y_next;
            r_rise    <= w_rise_nx;
            r_fall    <= w_fall_nx;
            r_pending <= (r_pending & ~i_clr) | o_y_next;
        end
    end

    assign o_y       = r_y;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_pending = r_pending;
endmodule

module multi_edge_detector #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int CNT_W         = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    multi_edge_detector_if.slave   bus
);
    localparam int F  = (FILTER_CYCLES > 1) ? FILTER_CYCLES : 1;
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] w_y_next, w_y, w_rise, w_fall, w_pending;
    logic [PW-1:0]    w_pop;
    logic [SW-1:0]    w_sum;
    logic [CNT_W-1:0] r_count;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            med_lane #(
                .SYNC_STAGES (SYNC_STAGES),
                .F           (F)
            ) u_lane (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .i_x       (bus.x[gi]),
                .i_mode    (bus.mode[2*gi+1:2*gi]),
                .i_clr     (bus.clr[gi]),
                .o_y_next  (w_y_next[gi]),
                .o_y       (w_y[gi]),
                .o_rise    (w_rise[gi]),
                .o_fall    (w_fall[gi]),
                .o_pending (w_pending[gi])
            );
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) w_pop = w_pop + PW'(w_y_next[i]);
    end

    // Sum is one bit wider than either operand so saturation never sees a wrap.
    assign w_sum = (bus.count_clr ? '0 : SW'(r_count)) + SW'(w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_count <= '0;
        else         r_count <= (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    assign bus.y           = w_y;
    assign bus.rise        = w_rise;
    assign bus.fall        = w_fall;
    assign bus.pending     = w_pending;
    assign bus.event_count = r_count;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: unit A (sync=2, no filter, 8-bit count) and
// unit B (no sync, 4-cycle filter, 4-bit count).
module tb_multi_edge_detector;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multi_edge_detector_if #(.WIDTH(8), .CNT_W(8)) ifa ();
    multi_edge_detector_if #(.WIDTH(8), .CNT_W(4)) ifb ();

    multi_edge_detector #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(0), .CNT_W(8))
        dut_a (.i_clk(clk), .i_reset(rst_a), .bus(ifa.slave));
    multi_edge_detector #(.WIDTH(8), .SYNC_STAGES(0), .FILTER_CYCLES(4), .CNT_W(4))
        dut_b (.i_clk(clk), .i_reset(rst_b), .bus(ifb.slave));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.x = '0; ifa.mode = 16'h0003; ifa.clr = '0; ifa.count_clr = 1'b0;
        ifb.x = '0; ifb.mode = 16'h5555; ifb.clr = '0; ifb.count_clr = 1'b0;
        tick(2);
        total++; if ({ifa.y, ifa.rise, ifa.fall, ifa.pending, ifa.event_count} !== 40'h0) begin
            bad++; $display("FAIL reset_a got=%h exp=0", {ifa.y, ifa.rise, ifa.fall, ifa.pending, ifa.event_count}); end
        total++; if ({ifb.y, ifb.rise, ifb.fall, ifb.pending, ifb.event_count} !== 36'h0) begin
            bad++; $display("FAIL reset_b got=%h exp=0", {ifb.y, ifb.rise, ifb.fall, ifb.pending, ifb.event_count}); end
        rst_a = 1'b0; rst_b = 1'b0;
        tick(2);
    endtask

    task automatic test_single_edge;
        ifa.x = 8'h01;
        tick(2);
        total++; if (ifa.y !== 8'h00) begin bad++; $display("FAIL early_y got=%h exp=00", ifa.y); end
        tick(1);
        total++; if (ifa.y !== 8'h01) begin bad++; $display("FAIL rise_y got=%h exp=01", ifa.y); end
        total++; if (ifa.rise !== 8'h01 || ifa.fall !== 8'h00) begin
            bad++; $display("FAIL rise_flags got=%h/%h exp=01/00", ifa.rise, ifa.fall); end
        tick(1);
        total++; if (ifa.y !== 8'h00 || ifa.rise !== 8'h00) begin
            bad++; $display("FAIL rise_one_cycle got=%h/%h exp=00/00", ifa.y, ifa.rise); end
        ifa.x = 8'h00;
        tick(3);
        total++; if (ifa.y !== 8'h01 || ifa.fall !== 8'h01 || ifa.rise !== 8'h00) begin
            bad++; $display("FAIL fall_y got=%h/%h/%h exp=01/01/00", ifa.y, ifa.fall, ifa.rise); end
        tick(1);
        total++; if (ifa.y !== 8'h00) begin bad++; $display("FAIL fall_one_cycle got=%h exp=00", ifa.y); end
        total++; if (ifa.pending !== 8'h01 || ifa.event_count !== 8'd2) begin
            bad++; $display("FAIL single_pend_cnt got=%h/%0d exp=01/2", ifa.pending, ifa.event_count); end
    endtask

    task automatic test_all_channels;
        ifa.mode = 16'hFFFF;
        ifa.clr = 8'hFF; ifa.count_clr = 1'b1;
        tick(1);
        ifa.clr = 8'h00; ifa.count_clr = 1'b0;
        total++; if (ifa.pending !== 8'h00 || ifa.event_count !== 8'd0) begin
            bad++; $display("FAIL clear_all got=%h/%0d exp=00/0", ifa.pending, ifa.event_count); end
        ifa.x = 8'hFF;
        tick(3);
        total++; if (ifa.y !== 8'hFF || ifa.event_count !== 8'd8) begin
            bad++; $display("FAIL all_rise got=%h/%0d exp=FF/8", ifa.y, ifa.event_count); end
        tick(1);
        total++; if (ifa.y !== 8'h00 || ifa.event_count !== 8'd8) begin
            bad++; $display("FAIL all_rise_after got=%h/%0d exp=00/8", ifa.y, ifa.event_count); end
        ifa.x = 8'h00;
        tick(3);
        total++; if (ifa.fall !== 8'hFF || ifa.event_count !== 8'd16) begin
            bad++; $display("FAIL all_fall got=%h/%0d exp=FF/16", ifa.fall, ifa.event_count); end
    endtask

    task automatic test_pending_clr;
        ifa.clr = 8'hFF;
        tick(1);
        ifa.clr = 8'h00;
        total++; if (ifa.pending !== 8'h00) begin bad++; $display("FAIL clr_level got=%h exp=00", ifa.pending); end
        ifa.x = 8'h08;
        tick(2);
        ifa.clr = 8'h08;
        tick(1);
        total++; if (ifa.pending !== 8'h08 || ifa.y !== 8'h08 || ifa.event_count !== 8'd17) begin
            bad++; $display("FAIL set_beats_clr got=%h/%h/%0d exp=08/08/17", ifa.pending, ifa.y, ifa.event_count); end
        tick(1);
        ifa.clr = 8'h00;
        total++; if (ifa.pending !== 8'h00) begin bad++; $display("FAIL clr_alone got=%h exp=00", ifa.pending); end
        ifa.x = 8'h0B;
        tick(2);
        ifa.count_clr = 1'b1;
        tick(1);
        ifa.count_clr = 1'b0;
        total++; if (ifa.y !== 8'h03 || ifa.event_count !== 8'd2) begin
            bad++; $display("FAIL count_clr_events got=%h/%0d exp=03/2", ifa.y, ifa.event_count); end
    endtask

    task automatic test_mode_off;
        ifa.mode = 16'hFCFF;
        ifa.x = 8'h1B;
        tick(3);
        total++; if (ifa.y !== 8'h00 || ifa.rise !== 8'h10) begin
            bad++; $display("FAIL off_rise got=%h/%h exp=00/10", ifa.y, ifa.rise); end
        tick(1);
        ifa.x = 8'h0B;
        tick(3);
        total++; if (ifa.y !== 8'h00 || ifa.fall !== 8'h10) begin
            bad++; $display("FAIL off_fall got=%h/%h exp=00/10", ifa.y, ifa.fall); end
        tick(1);
        ifa.mode = 16'hFFFF;
        tick(4);
        total++; if (ifa.y !== 8'h00 || ifa.event_count !== 8'd2) begin
            bad++; $display("FAIL reenable_quiet got=%h/%0d exp=00/2", ifa.y, ifa.event_count); end
        ifa.x = 8'h1B;
        tick(3);
        total++; if (ifa.y !== 8'h10 || ifa.event_count !== 8'd3) begin
            bad++; $display("FAIL reenable_toggle got=%h/%0d exp=10/3", ifa.y, ifa.event_count); end
    endtask

    task automatic test_glitch;
        int hits;
        hits = 0;
        ifb.x = 8'h01;
        for (int i = 0; i < 3; i++) begin tick(1); hits += int'(ifb.rise[0] | ifb.y[0]); end
        ifb.x = 8'h00;
        for (int i = 0; i < 5; i++) begin tick(1); hits += int'(ifb.rise[0] | ifb.y[0]); end
        total++; if (hits !== 0) begin bad++; $display("FAIL glitch_filtered got=%0d exp=0", hits); end
        ifb.x = 8'h01;
        tick(3);
        total++; if (ifb.rise !== 8'h00) begin bad++; $display("FAIL filter_early got=%h exp=00", ifb.rise); end
        tick(1);
        total++; if (ifb.y !== 8'h01 || ifb.rise !== 8'h01) begin
            bad++; $display("FAIL filter_rise got=%h/%h exp=01/01", ifb.y, ifb.rise); end
        ifb.x = 8'h00;
        tick(3);
        total++; if (ifb.fall !== 8'h00) begin bad++; $display("FAIL filter_fall_early got=%h exp=00", ifb.fall); end
        tick(1);
        total++; if (ifb.fall !== 8'h01 || ifb.y !== 8'h00 || ifb.rise !== 8'h00) begin
            bad++; $display("FAIL masked_fall got=%h/%h/%h exp=01/00/00", ifb.fall, ifb.y, ifb.rise); end
        total++; if (ifb.event_count !== 4'd1) begin bad++; $display("FAIL glitch_count got=%0d exp=1", ifb.event_count); end
    endtask

    task automatic test_saturate;
        ifb.mode = 16'hFFFF;
        ifb.count_clr = 1'b1;
        tick(1);
        ifb.count_clr = 1'b0;
        total++; if (ifb.event_count !== 4'd0) begin bad++; $display("FAIL sat_clear got=%0d exp=0", ifb.event_count); end
        ifb.x = 8'hFF;
        tick(4);
        total++; if (ifb.y !== 8'hFF || ifb.event_count !== 4'd8) begin
            bad++; $display("FAIL sat_first got=%h/%0d exp=FF/8", ifb.y, ifb.event_count); end
        ifb.x = 8'h00;
        tick(4);
        total++; if (ifb.event_count !== 4'd15) begin bad++; $display("FAIL sat_second got=%0d exp=15", ifb.event_count); end
        ifb.x = 8'hFF;
        tick(4);
        total++; if (ifb.y !== 8'hFF || ifb.event_count !== 4'd15) begin
            bad++; $display("FAIL sat_hold got=%h/%0d exp=FF/15", ifb.y, ifb.event_count); end
    endtask

    task automatic test_reset_mid;
        ifb.x = 8'h00;
        tick(4);
        ifb.x = 8'h01;
        tick(2);
        rst_b = 1'b1;
        tick(1);
        total++; if ({ifb.y, ifb.rise, ifb.fall, ifb.pending, ifb.event_count} !== 36'h0) begin
            bad++; $display("FAIL mid_reset got=%h exp=0", {ifb.y, ifb.rise, ifb.fall, ifb.pending, ifb.event_count}); end
        rst_b = 1'b0;
        tick(3);
        total++; if (ifb.rise !== 8'h00) begin bad++; $display("FAIL post_reset_early got=%h exp=00", ifb.rise); end
        tick(1);
        total++; if (ifb.rise !== 8'h01 || ifb.y !== 8'h01 || ifb.event_count !== 4'd1) begin
            bad++; $display("FAIL post_reset_rise got=%h/%h/%0d exp=01/01/1", ifb.rise, ifb.y, ifb.event_count); end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_all_channels();
        test_pending_clr();
        test_mode_off();
        test_glitch();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
